// File: rtl/axis_fifo_pkt_writer.sv
// Write-side packet framer: emits a sequence-tagged header word, then payload
// beats with an end-of-packet flag, truncating packets longer than MAX_BEATS.
module axis_fifo_pkt_writer #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              en,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              fifo_wr_en,
  output logic [DATA_W:0]   fifo_wr_data,
  input  logic              fifo_full,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  trunc_cnt
);

  localparam int BC_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;
  logic [CNT_W-1:0]  trunc_q, trunc_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0] hdr_word;
  logic              beat_last;
  logic              beat_acc;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      seq_q   <= '0;
      pkt_q   <= '0;
      trunc_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      pkt_q   <= pkt_d;
      trunc_q <= trunc_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    hdr_word              = '0;
    hdr_word[31:24]       = 8'hA5;
    hdr_word[CNT_W-1:0]   = seq_q;
  end

  assign beat_last = (beat_q == BC_W'(MAX_BEATS - 1));
  assign beat_acc  = s_tvalid && !fifo_full;

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    pkt_d        = pkt_q;
    trunc_d      = trunc_q;
    beat_d       = beat_q;
    s_tready     = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (state_q)
      IDLE: begin
        // First beat is held by the source until the header is out.
        if (en && s_tvalid) state_d = HDR;
      end
      HDR: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = {1'b0, hdr_word};
        if (!fifo_full) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        s_tready     = !fifo_full;
        fifo_wr_en   = beat_acc;
        fifo_wr_data = {s_tlast || beat_last, s_tdata};
        if (beat_acc) begin
          beat_d = beat_q + BC_W'(1);
          if (s_tlast) begin
            state_d = IDLE;
            seq_d   = seq_q + CNT_W'(1);
            pkt_d   = pkt_q + CNT_W'(1);
          end else if (beat_last) begin
            // Cut here; the tail of the packet is swallowed in DROP.
            state_d = DROP;
            seq_d   = seq_q + CNT_W'(1);
            pkt_d   = pkt_q + CNT_W'(1);
            trunc_d = trunc_q + CNT_W'(1);
          end
        end
      end
      DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign pkt_cnt   = pkt_q;
  assign trunc_cnt = trunc_q;

endmodule

// File: doc/axis_fifo_pkt_writer.md
Name: axis_fifo_pkt_writer

Overview:
- Write-side packet framer for the packet mover. Sits in the wclk domain between an AXI-Stream source and the write port of the dual-clock FIFO.
- For each packet it writes one header word tagged with a sequence number, then the payload beats, each with an end-of-packet flag in the FIFO word MSB.
- Packets longer than MAX_BEATS are cut at MAX_BEATS beats and the remaining input beats are discarded, so the read side never stalls on an unbounded packet.

Parameters:
- DATA_W, 32, payload width in bits; must be >= 32.
- MAX_BEATS, 256, maximum payload beats written per packet; must be >= 1.
- CNT_W, 16, width of the sequence and statistics counters; must be <= 16.

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- en  in  1  accept new packets when high; a packet in progress always completes
- s_tvalid  in  1  AXI-Stream valid
- s_tready  out  1  AXI-Stream ready
- s_tdata  in  DATA_W  AXI-Stream data
- s_tlast  in  1  AXI-Stream last
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_W+1  FIFO word: bit DATA_W = last flag, [DATA_W-1:0] = data
- fifo_full  in  1  FIFO full, registered in the wclk domain
- busy  out  1  high in any state other than IDLE
- pkt_cnt  out  CNT_W  completed packets, wraps
- trunc_cnt  out  CNT_W  truncated packets, wraps

Behaviour:
- Reset is asynchronous: wrst_n low clears all state immediately.
  - State = IDLE.
  - seq, beat_cnt, pkt_cnt and trunc_cnt = 0.
  - busy = 0, s_tready = 0, fifo_wr_en = 0, fifo_wr_data = 0.
- Reset mid-packet: words already written stay in the FIFO. The downstream side may see a packet without a last flag; that is accepted behaviour.
- Outputs s_tready, fifo_wr_en and fifo_wr_data are combinational from the state and inputs. All state is registered on the wclk rising edge.
- A FIFO write occurs only when fifo_wr_en is high and fifo_full is low. fifo_wr_en is never asserted while fifo_full is high.
- IDLE:
  - s_tready = 0, no write.
  - If en && s_tvalid, go to HDR. The first beat is held by the source because s_tready = 0.
- HDR:
  - fifo_wr_en = !fifo_full.
  - Header word: last = 0, data[31:24] = 8'hA5, data[23:CNT_W] = 0, data[CNT_W-1:0] = seq, data[DATA_W-1:32] = 0.
  - On a write, beat_cnt is cleared and the state goes to DATA.
  - s_tready = 0 in this state.
- DATA:
  - s_tready = !fifo_full; fifo_wr_en = s_tvalid && !fifo_full.
  - Word written: data = s_tdata, last = s_tlast || (beat_cnt == MAX_BEATS-1).
  - On each accepted beat, beat_cnt increments.
  - Accepted beat with s_tlast: go to IDLE; seq++ and pkt_cnt++.
  - Accepted beat with !s_tlast && beat_cnt == MAX_BEATS-1: go to DROP; trunc_cnt++, pkt_cnt++, seq++.
  - s_tlast on exactly the MAX_BEATS-th beat is a normal completion: no truncation and no DROP.
- DROP:
  - s_tready = 1 and fifo_wr_en = 0; beats are discarded.
  - Accepted beat with s_tlast: go to IDLE.
  - fifo_full has no effect in this state.
- Flow control: s_tvalid may drop mid-packet; the block simply waits in DATA. No beat is duplicated or lost while fifo_full toggles.
- Counter arithmetic: seq, pkt_cnt and trunc_cnt wrap modulo 2^CNT_W. beat_cnt is sized $clog2(MAX_BEATS+1) bits.
- en deasserted while in HDR, DATA or DROP has no effect until the state returns to IDLE.
- busy = (state != IDLE).
- Throughput: one header cycle per packet, then one beat per cycle when unstalled. Minimum IDLE-to-first-payload-write latency is 2 cycles: IDLE->HDR, then the header write.

Test Plan:
- Reset, en=1, one 4-beat packet with data 1..4, fifo_full=0 -> FIFO receives 5 words: {0,A5000000}, {0,1}, {0,2}, {0,3}, {1,4}; pkt_cnt=1; busy returns to 0.
- Three back-to-back 1-beat packets -> headers carry seq 0, 1, 2; each data word has last=1; pkt_cnt=3; trunc_cnt=0.
- MAX_BEATS=4 with a 7-beat packet -> 4 payload words are written, the 4th with last=1; beats 5-7 are accepted with s_tready=1 and not written; trunc_cnt=1. A follow-up packet's header carries seq 1.
- MAX_BEATS=4 with a packet of exactly 4 beats -> 4th word has last=1; trunc_cnt=0; state returns to IDLE, not DROP.
- fifo_full toggled pseudo-randomly during an 8-beat packet -> no write while full, and the FIFO contents equal header + 8 beats in order with no duplicates.
- wrst_n asserted mid-packet after 2 beats -> outputs clear asynchronously with counters at 0. The next packet's header carries seq 0 and is framed correctly.
